gmix_state_engine: RTL

Iterative, parametrised MixColumns engine for the AES datapath. It accepts a full multi-column state over a valid/ready handshake and latches a per-block forward/inverse mode. It transforms COLS_PER_CYCLE columns per clock using GF(2^8) arithmetic (polynomial 0x11b) and presents the result with backpressure. It generalises the single-column combinational mixer, adding InvMixColumns, column count, throughput selection and flow control. It sits between ShiftRows and AddRoundKey in the encrypt and decrypt round pipelines.

---
 rtl/gmix_state_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gmix_state_engine.sv
// Iterative AES MixColumns/InvMixColumns engine with valid/ready flow control.
// Define GMIX_INV_EN to build the inverse datapath; otherwise every block is MixColumns.
module gmix_state_engine #(
  parameter int NUM_COLS       = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NUM_COLS-1:0] in_state,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_COLS-1:0] out_state,
  output logic                  out_inv
);

  localparam int W     = 32 * NUM_COLS;
  localparam int N     = NUM_COLS / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] GRP_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] GRP_ONE  = CNT_W'(1);

  generate
    if ((NUM_COLS % COLS_PER_CYCLE) != 0) begin : g_cfg_err
      $error("gmix_state_engine: COLS_PER_CYCLE must divide NUM_COLS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] grp_r;
  logic [W-1:0]     work_r;
  logic [W-1:0]     mixed_s;
  logic             inv_r;
  logic             out_valid_r;
  int               idx_s;
  logic [31:0]      col_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] r0, r1, r2, r3;
    {r0, r1, r2, r3} = c;
    return {xtime(r0) ^ mul3(r1) ^ r2 ^ r3,
            r0 ^ xtime(r1) ^ mul3(r2) ^ r3,
            r0 ^ r1 ^ xtime(r2) ^ mul3(r3),
            mul3(r0) ^ r1 ^ r2 ^ xtime(r3)};
  endfunction

`ifdef GMIX_INV_EN
  // Inverse multiples from the x2/x4/x8 chain: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] r0, r1, r2, r3;
    {r0, r1, r2, r3} = c;
    return {mule(r0) ^ mulb(r1) ^ muld(r2) ^ mul9(r3),
            mul9(r0) ^ mule(r1) ^ mulb(r2) ^ muld(r3),
            muld(r0) ^ mul9(r1) ^ mule(r2) ^ mulb(r3),
            mulb(r0) ^ muld(r1) ^ mul9(r2) ^ mule(r3)};
  endfunction
`else
  logic unused_inv_s;
  assign unused_inv_s = in_inv;
`endif

  // Transform the current column group in place; other columns pass through.
  always_comb begin
    mixed_s = work_r;
    idx_s   = 0;
    col_s   = 32'h0000_0000;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      idx_s = int'(grp_r) * COLS_PER_CYCLE + j;
      col_s = work_r[W-1-32*idx_s -: 32];
`ifdef GMIX_INV_EN
      mixed_s[W-1-32*idx_s -: 32] = inv_r ? mix_inv(col_s) : mix_fwd(col_s);
`else
      mixed_s[W-1-32*idx_s -: 32] = mix_fwd(col_s);
`endif
    end
  end

  // Handshake FSM, group counter and working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grp_r       <= '0;
      work_r      <= '0;
      inv_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r  <= in_state;
`ifdef GMIX_INV_EN
            inv_r   <= in_inv;
`else
            inv_r   <= 1'b0;
`endif
            grp_r   <= '0;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          work_r <= mixed_s;
          if (grp_r == GRP_LAST) begin
            grp_r       <= '0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            grp_r <= grp_r + GRP_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          grp_r       <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign out_state = work_r;
  assign out_inv   = inv_r;

endmodule
